// File: rtl/hms_timer_core_if.sv
// Control, preset, count and display signals of the hours/minutes/seconds timer core.
// The master side drives the buttons, mode and preset fields and observes the counts and flags.
interface hms_timer_core_if;
  logic       i_run_btn;
  logic       i_lap_btn;
  logic       i_mode;
  logic       i_load;
  logic [6:0] i_pre_hour;
  logic [6:0] i_pre_min;
  logic [6:0] i_pre_sec;
  logic [6:0] o_cnt_hour;
  logic [6:0] o_cnt_min;
  logic [6:0] o_cnt_sec;
  logic [23:0] o_bcd;
  logic       o_running;
  logic       o_lap_active;
  logic       o_wrap;
  logic       o_done;

  modport master (
    output i_run_btn, i_lap_btn, i_mode, i_load, i_pre_hour, i_pre_min, i_pre_sec,
    input  o_cnt_hour, o_cnt_min, o_cnt_sec, o_bcd, o_running, o_lap_active, o_wrap, o_done
  );

  modport slave (
    input  i_run_btn, i_lap_btn, i_mode, i_load, i_pre_hour, i_pre_min, i_pre_sec,
    output o_cnt_hour, o_cnt_min, o_cnt_sec, o_bcd, o_running, o_lap_active, o_wrap, o_done
  );
endinterface

// File: rtl/hms_timer_core.sv
// Hours/minutes/seconds stopwatch / countdown core running off the 1 Hz tick.
// Provides preset load, run/pause toggle, lap freeze, a rollover pulse, a sticky
// countdown-done flag and six packed BCD digits for the seven-segment decoders.
module hms_timer_core #(
  parameter int SEC_MAX   = 59,
  parameter int MIN_MAX   = 59,
  parameter int HOUR_MAX  = 23,
  parameter bit START_RUN = 1'b1
) (
  input logic                 oneSecClk,
  input logic                 reset,
  hms_timer_core_if.slave     bus
);

  localparam logic [6:0] L_SEC_MAX  = 7'(SEC_MAX);
  localparam logic [6:0] L_MIN_MAX  = 7'(MIN_MAX);
  localparam logic [6:0] L_HOUR_MAX = 7'(HOUR_MAX);

  // Clamp a preset field to its terminal value.
  function automatic logic [6:0] sat_field(input logic [6:0] v, input logic [6:0] vmax);
    return (v > vmax) ? vmax : v;
  endfunction

  // Split a 0..99 binary value into {tens, ones} BCD nibbles.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

  logic [6:0] r_hour, r_min, r_sec;
  logic [6:0] r_lap_hour, r_lap_min, r_lap_sec;
  logic       r_running, r_lap_active, r_wrap, r_done;
  logic       r_run_prev, r_lap_prev;

  logic [6:0] w_hour_nxt, w_min_nxt, w_sec_nxt;
  logic       w_running_nxt, w_done_nxt, w_wrap_nxt;
  logic       w_run_edge, w_lap_edge, w_zero;
  logic [6:0] w_disp_hour, w_disp_min, w_disp_sec;

  assign w_run_edge = bus.i_run_btn & ~r_run_prev;
  assign w_lap_edge = bus.i_lap_btn & ~r_lap_prev;
  assign w_zero     = (r_hour == 7'd0) && (r_min == 7'd0) && (r_sec == 7'd0);

  // Next count and control state; later branches override earlier ones (load > run toggle > count).
  always_comb begin
    w_hour_nxt    = r_hour;
    w_min_nxt     = r_min;
    w_sec_nxt     = r_sec;
    w_running_nxt = r_running;
    w_done_nxt    = r_done;
    w_wrap_nxt    = 1'b0;

    if (r_running) begin
      if (!bus.i_mode) begin
        if (r_sec < L_SEC_MAX) begin
          w_sec_nxt = r_sec + 7'd1;
        end else begin
          w_sec_nxt = 7'd0;
          if (r_min < L_MIN_MAX) begin
            w_min_nxt = r_min + 7'd1;
          end else begin
            w_min_nxt = 7'd0;
            if (r_hour < L_HOUR_MAX) begin
              w_hour_nxt = r_hour + 7'd1;
            end else begin
              w_hour_nxt = 7'd0;
              w_wrap_nxt = 1'b1;
            end
          end
        end
      end else if (w_zero) begin
        // Already at zero while counting down: hold rather than underflow.
        w_running_nxt = 1'b0;
        w_done_nxt    = 1'b1;
      end else begin
        if (r_sec != 7'd0) begin
          w_sec_nxt = r_sec - 7'd1;
        end else begin
          w_sec_nxt = L_SEC_MAX;
          if (r_min != 7'd0) begin
            w_min_nxt = r_min - 7'd1;
          end else begin
            w_min_nxt  = L_MIN_MAX;
            w_hour_nxt = r_hour - 7'd1;
          end
        end
        if ((w_hour_nxt == 7'd0) && (w_min_nxt == 7'd0) && (w_sec_nxt == 7'd0)) begin
          w_running_nxt = 1'b0;
          w_done_nxt    = 1'b1;
        end
      end
    end

    if (w_run_edge) begin
      if (bus.i_mode && w_zero) begin
        // Starting a countdown from zero is refused and reported as done.
        w_running_nxt = 1'b0;
        w_done_nxt    = 1'b1;
      end else begin
        w_running_nxt = ~r_running;
        if (!bus.i_mode) w_done_nxt = 1'b0;
      end
    end

    if (bus.i_load) begin
      w_hour_nxt    = sat_field(bus.i_pre_hour, L_HOUR_MAX);
      w_min_nxt     = sat_field(bus.i_pre_min, L_MIN_MAX);
      w_sec_nxt     = sat_field(bus.i_pre_sec, L_SEC_MAX);
      w_running_nxt = 1'b0;
      w_done_nxt    = 1'b0;
      w_wrap_nxt    = 1'b0;
    end
  end

  // Register count, flags and button history; history resets high so a held button cannot toggle.
  always_ff @(posedge oneSecClk) begin
    if (!reset) begin
      r_hour     <= 7'd0;
      r_min      <= 7'd0;
      r_sec      <= 7'd0;
      r_running  <= START_RUN;
      r_done     <= 1'b0;
      r_wrap     <= 1'b0;
      r_run_prev <= 1'b1;
      r_lap_prev <= 1'b1;
    end else begin
      r_hour     <= w_hour_nxt;
      r_min      <= w_min_nxt;
      r_sec      <= w_sec_nxt;
      r_running  <= w_running_nxt;
      r_done     <= w_done_nxt;
      r_wrap     <= w_wrap_nxt;
      r_run_prev <= bus.i_run_btn;
      r_lap_prev <= bus.i_lap_btn;
    end
  end

  // Lap freeze: first edge snapshots the pre-update count, second edge releases the display.
  always_ff @(posedge oneSecClk) begin
    if (!reset) begin
      r_lap_active <= 1'b0;
      r_lap_hour   <= 7'd0;
      r_lap_min    <= 7'd0;
      r_lap_sec    <= 7'd0;
    end else if (w_lap_edge) begin
      if (!r_lap_active) begin
        r_lap_hour   <= r_hour;
        r_lap_min    <= r_min;
        r_lap_sec    <= r_sec;
        r_lap_active <= 1'b1;
      end else begin
        r_lap_active <= 1'b0;
      end
    end
  end

  assign w_disp_hour = r_lap_active ? r_lap_hour : r_hour;
  assign w_disp_min  = r_lap_active ? r_lap_min  : r_min;
  assign w_disp_sec  = r_lap_active ? r_lap_sec  : r_sec;

  assign bus.o_cnt_hour   = r_hour;
  assign bus.o_cnt_min    = r_min;
  assign bus.o_cnt_sec    = r_sec;
  assign bus.o_bcd        = {to_bcd(w_disp_hour), to_bcd(w_disp_min), to_bcd(w_disp_sec)};
  assign bus.o_running    = r_running;
  assign bus.o_lap_active = r_lap_active;
  assign bus.o_wrap       = r_wrap;
  assign bus.o_done       = r_done;

endmodule

// File: tb/tb_hms_timer_core.sv
// Directed bench for hms_timer_core with default parameters (59/59/23, START_RUN=1).
// Inputs change and outputs are sampled on the falling edge of oneSecClk.
module tb_hms_timer_core;
  logic oneSecClk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  hms_timer_core_if bus();

  hms_timer_core dut (
    .oneSecClk (oneSecClk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 oneSecClk = ~oneSecClk;

  task automatic step(input int n);
    repeat (n) @(negedge oneSecClk);
  endtask

  function automatic logic [20:0] cnt();
    return {bus.o_cnt_hour, bus.o_cnt_min, bus.o_cnt_sec};
  endfunction

  task automatic load_preset(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
    bus.i_pre_hour = h;
    bus.i_pre_min  = m;
    bus.i_pre_sec  = s;
    bus.i_load     = 1'b1;
    step(1);
    bus.i_load     = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.i_run_btn  = 1'b0;
    bus.i_lap_btn  = 1'b0;
    bus.i_mode     = 1'b0;
    bus.i_load     = 1'b0;
    bus.i_pre_hour = 7'd0;
    bus.i_pre_min  = 7'd0;
    bus.i_pre_sec  = 7'd0;
    step(2);
    n_checks++;
    if (cnt() !== {7'd0, 7'd0, 7'd0}) begin
      $display("FAIL rst_cnt: got %h want %h", cnt(), 21'h0); n_fail++;
    end
    n_checks++;
    if ({bus.o_running, bus.o_lap_active, bus.o_wrap, bus.o_done} !== 4'b1000) begin
      $display("FAIL rst_flags: got %b want 1000", {bus.o_running, bus.o_lap_active, bus.o_wrap, bus.o_done}); n_fail++;
    end
    n_checks++;
    if (bus.o_bcd !== 24'h000000) begin
      $display("FAIL rst_bcd: got %h want 000000", bus.o_bcd); n_fail++;
    end
  endtask

  task automatic test_count_up();
    reset = 1'b1;
    step(61);
    n_checks++;
    if (cnt() !== {7'd0, 7'd1, 7'd1}) begin
      $display("FAIL up61_cnt: got %h want %h", cnt(), {7'd0, 7'd1, 7'd1}); n_fail++;
    end
    n_checks++;
    if (bus.o_bcd !== 24'h000101) begin
      $display("FAIL up61_bcd: got %h want 000101", bus.o_bcd); n_fail++;
    end
    n_checks++;
    if (bus.o_wrap !== 1'b0) begin
      $display("FAIL up61_wrap: got %b want 0", bus.o_wrap); n_fail++;
    end
  endtask

  task automatic test_wrap();
    load_preset(7'd23, 7'd59, 7'd58);
    n_checks++;
    if ({cnt(), bus.o_running} !== {7'd23, 7'd59, 7'd58, 1'b0}) begin
      $display("FAIL wrap_load: got %h/%b want 23:59:58 stopped", cnt(), bus.o_running); n_fail++;
    end
    bus.i_run_btn = 1'b1;
    step(1);
    bus.i_run_btn = 1'b0;
    n_checks++;
    if ({cnt(), bus.o_running} !== {7'd23, 7'd59, 7'd58, 1'b1}) begin
      $display("FAIL wrap_run: got %h/%b want 23:59:58 running", cnt(), bus.o_running); n_fail++;
    end
    step(1);
    n_checks++;
    if ({cnt(), bus.o_wrap} !== {7'd23, 7'd59, 7'd59, 1'b0}) begin
      $display("FAIL wrap_e1: got %h/%b want 23:59:59 wrap 0", cnt(), bus.o_wrap); n_fail++;
    end
    n_checks++;
    if (bus.o_bcd !== 24'h235959) begin
      $display("FAIL wrap_bcd: got %h want 235959", bus.o_bcd); n_fail++;
    end
    step(1);
    n_checks++;
    if ({cnt(), bus.o_wrap} !== {7'd0, 7'd0, 7'd0, 1'b1}) begin
      $display("FAIL wrap_e2: got %h/%b want 0:0:0 wrap 1", cnt(), bus.o_wrap); n_fail++;
    end
    step(1);
    n_checks++;
    if ({cnt(), bus.o_wrap} !== {7'd0, 7'd0, 7'd1, 1'b0}) begin
      $display("FAIL wrap_e3: got %h/%b want 0:0:1 wrap 0", cnt(), bus.o_wrap); n_fail++;
    end
  endtask

  task automatic test_countdown();
    bus.i_mode = 1'b1;
    load_preset(7'd0, 7'd1, 7'd2);
    bus.i_run_btn = 1'b1;
    step(1);
    bus.i_run_btn = 1'b0;
    step(61);
    n_checks++;
    if ({cnt(), bus.o_running, bus.o_done} !== {7'd0, 7'd0, 7'd1, 1'b1, 1'b0}) begin
      $display("FAIL dn61: got %h run %b done %b want 0:0:1 run 1 done 0", cnt(), bus.o_running, bus.o_done); n_fail++;
    end
    step(1);
    n_checks++;
    if ({cnt(), bus.o_running, bus.o_done} !== {7'd0, 7'd0, 7'd0, 1'b0, 1'b1}) begin
      $display("FAIL dn62: got %h run %b done %b want 0:0:0 run 0 done 1", cnt(), bus.o_running, bus.o_done); n_fail++;
    end
    step(5);
    n_checks++;
    if ({cnt(), bus.o_done} !== {7'd0, 7'd0, 7'd0, 1'b1}) begin
      $display("FAIL dn_hold: got %h done %b want 0:0:0 done 1", cnt(), bus.o_done); n_fail++;
    end
    bus.i_run_btn = 1'b1;
    step(1);
    bus.i_run_btn = 1'b0;
    n_checks++;
    if ({cnt(), bus.o_running, bus.o_done} !== {7'd0, 7'd0, 7'd0, 1'b0, 1'b1}) begin
      $display("FAIL dn_rerun: got %h run %b done %b want 0:0:0 run 0 done 1", cnt(), bus.o_running, bus.o_done); n_fail++;
    end
  endtask

  task automatic test_lap();
    bus.i_mode = 1'b0;
    load_preset(7'd0, 7'd0, 7'd10);
    bus.i_run_btn = 1'b1;
    step(1);
    bus.i_run_btn = 1'b0;
    bus.i_lap_btn = 1'b1;
    step(1);
    bus.i_lap_btn = 1'b0;
    n_checks++;
    if ({bus.o_lap_active, bus.o_bcd, bus.o_cnt_sec} !== {1'b1, 24'h000010, 7'd11}) begin
      $display("FAIL lap_grab: got lap %b bcd %h sec %0d want 1 000010 11", bus.o_lap_active, bus.o_bcd, bus.o_cnt_sec); n_fail++;
    end
    step(4);
    n_checks++;
    if ({bus.o_bcd, bus.o_cnt_sec} !== {24'h000010, 7'd15}) begin
      $display("FAIL lap_frozen: got bcd %h sec %0d want 000010 15", bus.o_bcd, bus.o_cnt_sec); n_fail++;
    end
    bus.i_lap_btn = 1'b1;
    step(1);
    bus.i_lap_btn = 1'b0;
    n_checks++;
    if ({bus.o_lap_active, bus.o_bcd, bus.o_cnt_sec} !== {1'b0, 24'h000016, 7'd16}) begin
      $display("FAIL lap_release: got lap %b bcd %h sec %0d want 0 000016 16", bus.o_lap_active, bus.o_bcd, bus.o_cnt_sec); n_fail++;
    end
  endtask

  task automatic test_load_clamp();
    load_preset(7'd0, 7'd99, 7'd75);
    n_checks++;
    if ({cnt(), bus.o_running} !== {7'd0, 7'd59, 7'd59, 1'b0}) begin
      $display("FAIL clamp_ms: got %h run %b want 0:59:59 run 0", cnt(), bus.o_running); n_fail++;
    end
    n_checks++;
    if (bus.o_bcd !== 24'h005959) begin
      $display("FAIL clamp_bcd: got %h want 005959", bus.o_bcd); n_fail++;
    end
    bus.i_run_btn = 1'b1;
    load_preset(7'd127, 7'd0, 7'd0);
    bus.i_run_btn = 1'b0;
    n_checks++;
    if ({cnt(), bus.o_running} !== {7'd23, 7'd0, 7'd0, 1'b0}) begin
      $display("FAIL load_vs_run: got %h run %b want 23:0:0 run 0", cnt(), bus.o_running); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    load_preset(7'd5, 7'd4, 7'd2);
    bus.i_run_btn = 1'b1;
    step(1);
    step(1);
    n_checks++;
    if ({cnt(), bus.o_running} !== {7'd5, 7'd4, 7'd3, 1'b1}) begin
      $display("FAIL mid_cnt: got %h run %b want 5:4:3 run 1", cnt(), bus.o_running); n_fail++;
    end
    bus.i_lap_btn = 1'b1;
    step(1);
    bus.i_lap_btn = 1'b0;
    reset = 1'b0;
    step(1);
    n_checks++;
    if ({cnt(), bus.o_bcd} !== {21'h0, 24'h0}) begin
      $display("FAIL mid_rst_cnt: got %h bcd %h want 0 and 000000", cnt(), bus.o_bcd); n_fail++;
    end
    n_checks++;
    if ({bus.o_running, bus.o_lap_active, bus.o_wrap, bus.o_done} !== 4'b1000) begin
      $display("FAIL mid_rst_flags: got %b want 1000", {bus.o_running, bus.o_lap_active, bus.o_wrap, bus.o_done}); n_fail++;
    end
    reset = 1'b1;
    step(1);
    n_checks++;
    if ({cnt(), bus.o_running} !== {7'd0, 7'd0, 7'd1, 1'b1}) begin
      $display("FAIL held_btn_1: got %h run %b want 0:0:1 run 1", cnt(), bus.o_running); n_fail++;
    end
    step(1);
    n_checks++;
    if ({cnt(), bus.o_running} !== {7'd0, 7'd0, 7'd2, 1'b1}) begin
      $display("FAIL held_btn_2: got %h run %b want 0:0:2 run 1", cnt(), bus.o_running); n_fail++;
    end
    bus.i_run_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_countdown();
    test_lap();
    test_load_clamp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
